// File: rtl/execute_cc_mreg.sv
// execute_cc_mreg: Y86-64 execute back end - condition codes, jXX/cmovXX condition and E->M register
module execute_cc_mreg #(
    parameter int         W         = 64,
    parameter logic [3:0] RNONE     = 4'hF,
    parameter logic [3:0] STAT_AOK  = 4'd1,
    parameter logic [3:0] ICODE_NOP = 4'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    input  logic [W-1:0] e_valE,
    input  logic         m_exc,
    input  logic         W_exc,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic         e_Cnd,
    output logic [3:0]   e_dstE,
    output logic [2:0]   cc,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);
    logic sa, sb, sr, new_of, set_cc, zf, sf, of_f, lt;
    logic unused_bits;
    assign unused_bits = ^{alu_a[W-2:0], alu_b[W-2:0]};
    assign sa = alu_a[W-1];
    assign sb = alu_b[W-1];
    assign sr = e_valE[W-1];
    assign new_of = E_ifun == 4'd0 ? (sa == sb) && (sr != sa) :
                    E_ifun == 4'd1 ? (sa != sb) && (sr != sa) : 1'b0;
    assign set_cc = (E_icode == 4'h6) && !m_exc && !W_exc && !M_stall;
    assign {zf, sf, of_f} = cc;
    assign lt = sf ^ of_f;
    always_comb begin
        e_Cnd = E_ifun == 4'd0 ? 1'b1 :
                E_ifun == 4'd1 ? lt | zf :
                E_ifun == 4'd2 ? lt :
                E_ifun == 4'd3 ? zf :
                E_ifun == 4'd4 ? !zf :
                E_ifun == 4'd5 ? !lt :
                E_ifun == 4'd6 ? !lt && !zf : 1'b0;
        e_dstE = (E_icode == 4'h2 && !e_Cnd) ? RNONE : E_dstE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cc <= 3'b100;
        else if (set_cc)
            cc <= {e_valE == '0, sr, new_of};
    end
    // Stall outranks bubble: a held instruction must not be overwritten by a nop
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!M_stall && M_bubble)) begin
            M_stat  <= STAT_AOK;
            M_icode <= ICODE_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end
endmodule

// File: tb/tb_execute_cc_mreg.sv
// tb_execute_cc_mreg: scoreboard bench for the execute back end against a flag/condition reference model
module tb_execute_cc_mreg;
    localparam int W = 64;
    localparam logic [3:0] RN = 4'hF;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] E_stat, E_icode, E_ifun, E_dstE, E_dstM;
    logic [W-1:0] E_valA, alu_a, alu_b, e_valE;
    logic m_exc, W_exc, M_stall, M_bubble;
    logic e_Cnd, M_Cnd;
    logic [3:0] e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic [2:0] cc;
    logic [W-1:0] M_valE, M_valA;
    always #5 clk = ~clk;
    execute_cc_mreg dut (
        .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM), .alu_a(alu_a), .alu_b(alu_b),
        .e_valE(e_valE), .m_exc(m_exc), .W_exc(W_exc), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_Cnd(e_Cnd), .e_dstE(e_dstE), .cc(cc), .M_stat(M_stat), .M_icode(M_icode),
        .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );
    typedef struct {
        logic         cnd;
        logic [3:0]   dste;
        logic [2:0]   cc;
        logic [3:0]   stat, icode;
        logic         mcnd;
        logic [W-1:0] vale, vala;
        logic [3:0]   mdste, mdstm;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] r_cc;
    logic [3:0] r_stat, r_icode, r_dste, r_dstm;
    logic r_cnd;
    logic [W-1:0] r_vale, r_vala;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic reset_m();
        r_stat = 4'd1; r_icode = 4'd1; r_cnd = 1'b0;
        r_vale = '0; r_vala = '0; r_dste = RN; r_dstm = RN;
    endtask
    // Condition from flags: lt means the signed comparison result was negative
    function automatic logic cond_of(input logic [3:0] f, input logic [2:0] c);
        logic z, lt;
        z = c[2];
        lt = c[1] ^ c[0];
        case (f)
            4'd0: return 1'b1;
            4'd1: return lt || z;
            4'd2: return lt;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return !lt;
            4'd6: return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction
    // Overflow as "true signed result does not fit in W bits"
    function automatic logic [2:0] flags_of(input logic [3:0] f, input logic [W-1:0] a, b, v);
        logic [W:0] t;
        logic o;
        t = '0;
        o = 1'b0;
        if (f == 4'd0) begin
            t = {a[W-1], a} + {b[W-1], b};
            o = t[W] != t[W-1];
        end else if (f == 4'd1) begin
            t = {a[W-1], a} - {b[W-1], b};
            o = t[W] != t[W-1];
        end
        return {v == '0, v[W-1], o};
    endfunction
    task automatic drive(input logic [3:0] st, ic, fn, input logic [W-1:0] va, a, b,
                         input logic [3:0] de, dm, input logic mx, wx, stl, bub);
        logic [W-1:0] v;
        exp_t e;
        v = fn == 4'd0 ? a + b : fn == 4'd1 ? a - b : fn == 4'd2 ? a & b :
            fn == 4'd3 ? a ^ b : {$urandom, $urandom};
        E_stat = st; E_icode = ic; E_ifun = fn; E_valA = va; E_dstE = de; E_dstM = dm;
        alu_a = a; alu_b = b; e_valE = v; m_exc = mx; W_exc = wx; M_stall = stl; M_bubble = bub;
        e.cnd = cond_of(fn, r_cc);
        e.dste = (ic == 4'h2 && !e.cnd) ? RN : de;
        if (ic == 4'h6 && !mx && !wx && !stl) r_cc = flags_of(fn, a, b, v);
        if (!stl && bub) reset_m();
        else if (!stl) begin
            r_stat = st; r_icode = ic; r_cnd = e.cnd; r_vale = v; r_vala = va;
            r_dste = e.dste; r_dstm = dm;
        end
        e.cc = r_cc; e.stat = r_stat; e.icode = r_icode; e.mcnd = r_cnd;
        e.vale = r_vale; e.vala = r_vala; e.mdste = r_dste; e.mdstm = r_dstm;
        q.push_back(e);
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return W'($urandom_range(0, 7));
            default: return {$urandom, $urandom};
        endcase
    endfunction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                chk("e_Cnd", 64'(e_Cnd), 64'(q[0].cnd));
                chk("e_dstE", 64'(e_dstE), 64'(q[0].dste));
            end
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cc", 64'(cc), 64'(e.cc));
                chk("M_stat", 64'(M_stat), 64'(e.stat));
                chk("M_icode", 64'(M_icode), 64'(e.icode));
                chk("M_Cnd", 64'(M_Cnd), 64'(e.mcnd));
                chk("M_valE", M_valE, e.vale);
                chk("M_valA", M_valA, e.vala);
                chk("M_dstE", 64'(M_dstE), 64'(e.mdste));
                chk("M_dstM", 64'(M_dstM), 64'(e.mdstm));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        logic [3:0] ic, fn;
        logic [W-1:0] a, b;
        E_stat = 4'd1; E_icode = 4'd1; E_ifun = 4'd0; E_valA = '0; E_dstE = RN; E_dstM = RN;
        alu_a = '0; alu_b = '0; e_valE = '0; m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
        r_cc = 3'b100;
        reset_m();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cc", 64'(cc), 64'b100);
        chk("rst_M_stat", 64'(M_stat), 64'd1);
        chk("rst_M_icode", 64'(M_icode), 64'd1);
        chk("rst_M_Cnd", 64'(M_Cnd), 64'd0);
        chk("rst_M_valE", M_valE, 64'd0);
        chk("rst_M_dstE", 64'(M_dstE), 64'hF);
        chk("rst_M_dstM", 64'(M_dstM), 64'hF);
        rst = 1'b0;
        drive(4'd1, 4'h1, 4'd0, '0, '0, '0, RN, RN, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("nop_cc", 64'(cc), 64'b100);
        chk("nop_M_icode", 64'(M_icode), 64'd1);
        drive(4'd1, 4'h6, 4'd0, 64'h11, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
              4'd2, RN, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("add_cc", 64'(cc), 64'b011);
        chk("add_M_valE", M_valE, 64'h8000_0000_0000_0000);
        drive(4'd1, 4'h6, 4'd1, '0, 64'd5, 64'd5, 4'd2, RN, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("sub_mexc_cc", 64'(cc), 64'b011);
        drive(4'd1, 4'h6, 4'd1, '0, 64'd5, 64'd5, 4'd2, RN, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("sub_cc", 64'(cc), 64'b100);
        drive(4'd1, 4'h6, 4'd1, '0, 64'd0, 64'd1, 4'd2, RN, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("lt_cc", 64'(cc), 64'b010);
        drive(4'd1, 4'h2, 4'd2, 64'h77, '0, '0, 4'd3, RN, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("cmovl_e_Cnd", 64'(e_Cnd), 64'd1);
        tick();
        chk("cmovl_M_dstE", 64'(M_dstE), 64'd3);
        drive(4'd1, 4'h2, 4'd5, 64'h77, '0, '0, 4'd3, RN, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("cmovge_e_Cnd", 64'(e_Cnd), 64'd0);
        chk("cmovge_e_dstE", 64'(e_dstE), 64'hF);
        tick();
        chk("cmovge_M_Cnd", 64'(M_Cnd), 64'd0);
        drive(4'd1, 4'h3, 4'd0, '0, 64'hDEAD, '0, 4'd4, RN, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        repeat (3) begin
            drive(4'd1, 4'h6, 4'd0, 64'h5, 64'h1234, 64'h1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        end
        chk("stall_M_valE", M_valE, 64'hDEAD);
        drive(4'd1, 4'h6, 4'd0, 64'h5, 64'h1234, 64'h1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1, 1'b1); tick();
        chk("stall_bub_M_valE", M_valE, 64'hDEAD);
        chk("stall_bub_M_icode", 64'(M_icode), 64'd3);
        drive(4'd1, 4'h6, 4'd0, 64'h5, 64'h1234, 64'h1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        chk("bub_M_icode", 64'(M_icode), 64'd1);
        chk("bub_M_dstM", 64'(M_dstM), 64'hF);
        drive(4'd1, 4'h6, 4'd0, '0, 64'd1, 64'd1, 4'd2, RN, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("pre_rst_M_icode", 64'(M_icode), 64'd6);
        #1 rst = 1'b1;
        #1;
        r_cc = 3'b100;
        reset_m();
        chk("arst_M_icode", 64'(M_icode), 64'd1);
        chk("arst_cc", 64'(cc), 64'b100);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ic = 4'h6;
                4, 5: ic = 4'h2;
                6: ic = 4'h7;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            fn = ic == 4'h6 ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 8));
            a = rnd_op();
            b = ($urandom_range(0, 4) == 0) ? a : rnd_op();
            drive(4'($urandom_range(0, 4)), ic, fn, {$urandom, $urandom}, a, b,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            tick();
        end
        chk("queue_drain", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
